flush_controller_mw: RTL and testbench

- Multi-lane successor of the scalar flush controller.
- Records the fall-through/actual next PC following every fetched branch into a DEPTH-entry FIFO, covering up to FETCH_W lanes per cycle.
- Compares each branch resolution from execute against the FIFO head and raises a registered flush with the correct address, ROB ticket and RAT id.
- Adds resolution back-pressure, a one-entry early-resolution buffer, an external flush input and saturating statistics counters.

---
 rtl/flush_controller_mw.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_flush_controller_mw.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flush_controller_mw.sv
// flush_controller_mw
//
// Multi-lane branch flush controller. Every fetched branch leaves its
// fall-through address in a DEPTH-entry next-PC FIFO, with up to FETCH_W
// lanes captured per cycle. Each branch resolution from execute is compared
// against the FIFO head. On a mismatch, a registered one-cycle flush is
// raised that carries the correct address, the ROB ticket and the RAT id.
// A resolution that arrives before its next PC has been captured waits in a
// one-entry early-resolution buffer.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   fetch_valid       per-lane valid, lane 0 oldest
//   fetch_is_branch   per-lane branch/jump flag
//   fetch_pc          per-lane PC, lane i at [32i+31:32i]
//   fetch_ready       room for a full fetch group and no flush in progress
//   res_valid/ready   branch resolution handshake
//   res_taken, res_csr, res_is_comp, res_pc, res_target,
//   res_ticket, res_rat_id   resolution payload
//   ext_flush         external squash: clears state, produces no flush output
//   flush_valid       one-cycle misprediction pulse
//   flush_delayed     the flush came from the early-resolution buffer
//   flush_addr, flush_ticket, flush_rat_id   redirect payload
//   stat_branches     saturating count of resolutions compared
//   stat_mispredicts  saturating count of flushes raised
//
// Handshakes: a transfer happens on a rising clk edge where both valid and
// ready are high. Ready never depends on the same-cycle valid. Each ready is
// a function of registered state only. When ready is low, the inputs are
// ignored, and the producer keeps its request until the transfer completes.

module flush_controller_mw #(
  parameter int FETCH_W        = 2,
  parameter int DEPTH          = 8,
  parameter int ROB_INDEX_BITS = 3,
  parameter int MAX_BRANCH_IF  = 2,
  parameter int CNT_W          = 16,
  localparam int RAT_W         = (MAX_BRANCH_IF > 1) ? $clog2(MAX_BRANCH_IF) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [FETCH_W-1:0]        fetch_valid,
  input  logic [FETCH_W-1:0]        fetch_is_branch,
  input  logic [32*FETCH_W-1:0]     fetch_pc,
  output logic                      fetch_ready,
  input  logic                      res_valid,
  output logic                      res_ready,
  input  logic                      res_taken,
  input  logic                      res_csr,
  input  logic                      res_is_comp,
  input  logic [31:0]               res_pc,
  input  logic [31:0]               res_target,
  input  logic [ROB_INDEX_BITS-1:0] res_ticket,
  input  logic [RAT_W-1:0]          res_rat_id,
  input  logic                      ext_flush,
  output logic                      flush_valid,
  output logic                      flush_delayed,
  output logic [31:0]               flush_addr,
  output logic [ROB_INDEX_BITS-1:0] flush_ticket,
  output logic [RAT_W-1:0]          flush_rat_id,
  output logic [CNT_W-1:0]          stat_branches,
  output logic [CNT_W-1:0]          stat_mispredicts
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_BITS = PTR_W + 1;

  // ST_RUN   : normal operation, resolutions accepted
  // ST_PEND  : an early resolution waits for its next PC to be captured
  // ST_FLUSH : flush_valid cycle, all inputs ignored
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PEND  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Next-PC FIFO
  logic [31:0]         mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_BITS-1:0] count;
  logic [CNT_BITS-1:0] free_slots;
  logic                fifo_empty;
  logic [31:0]         head;

  // Capture
  logic                must_capture;
  logic [FETCH_W-1:0]  lane_push;
  logic [PTR_W-1:0]    lane_addr [FETCH_W];
  logic [CNT_BITS-1:0] npush;
  logic                prev_cap;
  logic                last_is_branch;
  logic                fetch_fire;

  // Resolution
  logic                      res_fire;
  logic [31:0]               correct_addr;
  logic [31:0]               pend_addr;
  logic [ROB_INDEX_BITS-1:0] pend_ticket;
  logic [RAT_W-1:0]          pend_rat;

  logic                      pop;
  logic                      do_compare;
  logic                      to_pending;
  logic                      csr_flush;
  logic                      flush_decide;
  logic                      clear_all;
  logic [31:0]               cmp_addr;
  logic [ROB_INDEX_BITS-1:0] cmp_ticket;
  logic [RAT_W-1:0]          cmp_rat;
  logic                      cmp_delayed;

  assign free_slots = CNT_BITS'(DEPTH) - count;
  assign fifo_empty = (count == '0);
  assign head       = mem[rd_ptr];

  // ---------------------------------------------------------------------
  // FSM output process
  // ---------------------------------------------------------------------
  always_comb begin
    res_ready   = (state == ST_RUN);
    flush_valid = (state == ST_FLUSH);
    fetch_ready = (state != ST_FLUSH) && (free_slots >= CNT_BITS'(FETCH_W));
  end

  assign fetch_fire = fetch_ready && (|fetch_valid);
  assign res_fire   = res_valid && res_ready;

  // ---------------------------------------------------------------------
  // Lane capture. A lane's PC is the next PC of the branch in the previous
  // lane. For lane 0, the previous lane is the last valid lane of the
  // previous fetch group, which must_capture remembers. Pushes are compacted
  // so that the captured PCs occupy consecutive FIFO slots in lane order.
  // ---------------------------------------------------------------------
  always_comb begin
    lane_push      = '0;
    npush          = '0;
    prev_cap       = must_capture;
    last_is_branch = must_capture;
    for (int i = 0; i < FETCH_W; i++) begin
      lane_addr[i] = wr_ptr + npush[PTR_W-1:0];
      if (fetch_valid[i] && fetch_ready && prev_cap) begin
        lane_push[i] = 1'b1;
        npush        = npush + CNT_BITS'(1);
      end
      prev_cap = fetch_valid[i] && fetch_is_branch[i];
      if (fetch_valid[i]) begin
        last_is_branch = fetch_is_branch[i];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Resolution decision. A waiting early resolution is served first. While
  // it waits, res_ready is low, so it never competes with a new resolution.
  // ---------------------------------------------------------------------
  always_comb begin
    if (res_taken || res_csr) begin
      correct_addr = res_target;
    end else if (res_is_comp) begin
      correct_addr = res_pc + 32'd2;
    end else begin
      correct_addr = res_pc + 32'd4;
    end
  end

  always_comb begin
    pop         = 1'b0;
    do_compare  = 1'b0;
    to_pending  = 1'b0;
    csr_flush   = 1'b0;
    cmp_addr    = correct_addr;
    cmp_ticket  = res_ticket;
    cmp_rat     = res_rat_id;
    cmp_delayed = 1'b0;
    if (!ext_flush) begin
      if (state == ST_PEND) begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          do_compare  = 1'b1;
          cmp_addr    = pend_addr;
          cmp_ticket  = pend_ticket;
          cmp_rat     = pend_rat;
          cmp_delayed = 1'b1;
        end
      end else if (res_fire) begin
        if (res_csr) begin
          csr_flush = 1'b1;
        end else if (!fifo_empty) begin
          pop        = 1'b1;
          do_compare = 1'b1;
        end else begin
          // A push in this same cycle is not yet visible to the head,
          // so the resolution must wait in the buffer.
          to_pending = 1'b1;
        end
      end
    end
  end

  assign flush_decide = csr_flush || (do_compare && (head != cmp_addr));
  assign clear_all    = ext_flush || flush_decide;

  // ---------------------------------------------------------------------
  // FSM next-state process
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (ext_flush) begin
      state_nxt = ST_RUN;
    end else if (flush_decide) begin
      state_nxt = ST_FLUSH;
    end else if (to_pending) begin
      state_nxt = ST_PEND;
    end else begin
      case (state)
        ST_PEND:  if (!fifo_empty) state_nxt = ST_RUN;
        ST_FLUSH: state_nxt = ST_RUN;
        default:  state_nxt = ST_RUN;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FIFO storage. The data needs no reset: occupancy is tracked in count.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_W; i++) begin
      if (lane_push[i]) begin
        mem[lane_addr[i]] <= fetch_pc[32*i +: 32];
      end
    end
  end

  // Pointers wrap naturally at DEPTH (power of two). Count tells full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear_all) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + npush[PTR_W-1:0];
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + npush - CNT_BITS'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      must_capture <= 1'b0;
    end else if (clear_all) begin
      must_capture <= 1'b0;
    end else if (fetch_fire) begin
      must_capture <= last_is_branch;
    end
  end

  // Early-resolution payload. Its validity is carried by state == ST_PEND.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_addr   <= '0;
      pend_ticket <= '0;
      pend_rat    <= '0;
    end else if (to_pending) begin
      pend_addr   <= correct_addr;
      pend_ticket <= res_ticket;
      pend_rat    <= res_rat_id;
    end
  end

  // Flush payload. It is held only for the single flush_valid cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_delayed <= 1'b0;
      flush_addr    <= '0;
      flush_ticket  <= '0;
      flush_rat_id  <= '0;
    end else if (flush_decide) begin
      flush_delayed <= cmp_delayed;
      flush_addr    <= cmp_addr;
      flush_ticket  <= cmp_ticket;
      flush_rat_id  <= cmp_rat;
    end else begin
      flush_delayed <= 1'b0;
      flush_addr    <= '0;
      flush_ticket  <= '0;
      flush_rat_id  <= '0;
    end
  end

  // Statistics saturate and are cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (do_compare && (stat_branches != '1)) begin
        stat_branches <= stat_branches + CNT_W'(1);
      end
      if (flush_decide && (stat_mispredicts != '1)) begin
        stat_mispredicts <= stat_mispredicts + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_flush_controller_mw.sv
// Bench for flush_controller_mw: directed vectors, expected flushes queued
// by the stimulus, checked by a negedge monitor.

module tb_flush_controller_mw;

  localparam int FETCH_W        = 2;
  localparam int DEPTH          = 8;
  localparam int ROB_INDEX_BITS = 3;
  localparam int MAX_BRANCH_IF  = 2;
  localparam int CNT_W          = 16;
  localparam int RAT_W          = 1;
  localparam int FLUSH_W        = 1 + RAT_W + ROB_INDEX_BITS + 32;

  logic                      clk;
  logic                      rst;
  logic [FETCH_W-1:0]        fetch_valid;
  logic [FETCH_W-1:0]        fetch_is_branch;
  logic [32*FETCH_W-1:0]     fetch_pc;
  logic                      fetch_ready;
  logic                      res_valid;
  logic                      res_ready;
  logic                      res_taken;
  logic                      res_csr;
  logic                      res_is_comp;
  logic [31:0]               res_pc;
  logic [31:0]               res_target;
  logic [ROB_INDEX_BITS-1:0] res_ticket;
  logic [RAT_W-1:0]          res_rat_id;
  logic                      ext_flush;
  logic                      flush_valid;
  logic                      flush_delayed;
  logic [31:0]               flush_addr;
  logic [ROB_INDEX_BITS-1:0] flush_ticket;
  logic [RAT_W-1:0]          flush_rat_id;
  logic [CNT_W-1:0]          stat_branches;
  logic [CNT_W-1:0]          stat_mispredicts;

  int n_checks = 0;
  int n_fail   = 0;

  // expected flushes: {delayed, rat_id, ticket, addr}
  logic [FLUSH_W-1:0] exp_q[$];
  // next PCs the bench expects to sit in the DUT FIFO, oldest first
  logic [31:0]        model_q[$];
  logic [FLUSH_W-1:0] mon_exp;
  logic [FLUSH_W-1:0] mon_act;

  flush_controller_mw #(
    .FETCH_W(FETCH_W), .DEPTH(DEPTH), .ROB_INDEX_BITS(ROB_INDEX_BITS),
    .MAX_BRANCH_IF(MAX_BRANCH_IF), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_is_branch(fetch_is_branch),
    .fetch_pc(fetch_pc), .fetch_ready(fetch_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
    .res_csr(res_csr), .res_is_comp(res_is_comp), .res_pc(res_pc),
    .res_target(res_target), .res_ticket(res_ticket), .res_rat_id(res_rat_id),
    .ext_flush(ext_flush),
    .flush_valid(flush_valid), .flush_delayed(flush_delayed),
    .flush_addr(flush_addr), .flush_ticket(flush_ticket),
    .flush_rat_id(flush_rat_id),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && flush_valid) begin
      n_checks++;
      mon_act = {flush_delayed, flush_rat_id, flush_ticket, flush_addr};
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL flush_unexpected: got addr=%h ticket=%0d rat=%0d delayed=%0b, required no flush",
                 flush_addr, flush_ticket, flush_rat_id, flush_delayed);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          n_fail++;
          $display("FAIL flush_payload: got {delayed,rat,ticket,addr}=%h required %h", mon_act, mon_exp);
        end
      end
    end
  end

  // A fetch must never be presented while fetch_ready is low.
  always @(posedge clk) begin
    if (!rst && (|fetch_valid) && !fetch_ready) begin
      n_fail++;
      $display("FAIL fetch_protocol: got fetch_valid=%b with fetch_ready=0, required no fetch", fetch_valid);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input bit want_fetch, input bit want_res, input string who);
    int n;
    n = 0;
    while (((want_fetch && !fetch_ready) || (want_res && !res_ready)) && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got ready low for 50 cycles, required ready", who);
    end
  endtask

  task automatic set_fetch(input logic [1:0] v, input logic [1:0] br,
                           input logic [31:0] pc0, input logic [31:0] pc1);
    fetch_valid     = v;
    fetch_is_branch = br;
    fetch_pc        = {pc1, pc0};
  endtask

  task automatic set_res(input logic taken, input logic csr, input logic comp,
                         input logic [31:0] pc, input logic [31:0] target,
                         input logic [2:0] ticket, input logic rat);
    res_valid   = 1'b1;
    res_taken   = taken;
    res_csr     = csr;
    res_is_comp = comp;
    res_pc      = pc;
    res_target  = target;
    res_ticket  = ticket;
    res_rat_id  = rat;
  endtask

  task automatic clear_inputs();
    fetch_valid     = '0;
    fetch_is_branch = '0;
    fetch_pc        = '0;
    res_valid       = 1'b0;
    res_taken       = 1'b0;
    res_csr         = 1'b0;
    res_is_comp     = 1'b0;
    res_pc          = '0;
    res_target      = '0;
    res_ticket      = '0;
    res_rat_id      = '0;
    ext_flush       = 1'b0;
  endtask

  task automatic do_fetch(input logic [1:0] v, input logic [1:0] br,
                          input logic [31:0] pc0, input logic [31:0] pc1);
    wait_ready(1'b1, 1'b0, "fetch");
    set_fetch(v, br, pc0, pc1);
    step();
    clear_inputs();
  endtask

  task automatic do_res(input logic taken, input logic csr, input logic comp,
                        input logic [31:0] pc, input logic [31:0] target,
                        input logic [2:0] ticket, input logic rat);
    wait_ready(1'b0, 1'b1, "res");
    set_res(taken, csr, comp, pc, target, ticket, rat);
    step();
    clear_inputs();
  endtask

  task automatic do_both(input logic [31:0] pc0, input logic [31:0] pc1, input logic [31:0] target);
    wait_ready(1'b1, 1'b1, "both");
    set_fetch(2'b11, 2'b11, pc0, pc1);
    set_res(1'b1, 1'b0, 1'b0, 32'h0, target, 3'd0, 1'b0);
    step();
    clear_inputs();
  endtask

  // pop the bench's FIFO model and resolve taken to exactly that address
  task automatic res_matching_head();
    logic [31:0] t;
    t = model_q.pop_front();
    do_res(1'b1, 1'b0, 1'b0, t - 32'h20, t, 3'd0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    check("rst_fetch_ready", 32'(fetch_ready), 32'd1);
    check("rst_res_ready", 32'(res_ready), 32'd1);
    check("rst_flush_valid", 32'(flush_valid), 32'd0);
    check("rst_flush_addr", flush_addr, 32'd0);
    check("rst_stat_branches", 32'(stat_branches), 32'd0);
    check("rst_stat_mispredicts", 32'(stat_mispredicts), 32'd0);

    // T1: branch at 0x100 in lane 0 -> 0x104 captured, not-taken matches
    do_fetch(2'b11, 2'b01, 32'h100, 32'h104);
    do_res(1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 3'd1, 1'b0);
    check("t1_no_flush", 32'(flush_valid), 32'd0);
    check("t1_stat_branches", 32'(stat_branches), 32'd1);

    // T2: branch at 0x200 in lane 1, next group lane 0 0x300 captured;
    //     taken to 0x240 mismatches
    do_fetch(2'b11, 2'b10, 32'h1FC, 32'h200);
    do_fetch(2'b01, 2'b00, 32'h300, 32'h304);
    exp_q.push_back({1'b0, 1'b1, 3'd3, 32'h240});
    do_res(1'b1, 1'b0, 1'b0, 32'h200, 32'h240, 3'd3, 1'b1);
    check("t2_flush_valid", 32'(flush_valid), 32'd1);
    check("t2_fetch_ready_low", 32'(fetch_ready), 32'd0);
    check("t2_res_ready_low", 32'(res_ready), 32'd0);
    step();
    check("t2_flush_one_cycle", 32'(flush_valid), 32'd0);

    // T3: early resolution (ticket 5, correct 0x208), then 0x204 captured
    do_res(1'b0, 1'b0, 1'b0, 32'h204, 32'h0, 3'd5, 1'b0);
    check("t3_res_ready_pending", 32'(res_ready), 32'd0);
    exp_q.push_back({1'b1, 1'b0, 3'd5, 32'h208});
    do_fetch(2'b11, 2'b01, 32'h200, 32'h204);
    check("t3_still_pending", 32'(res_ready), 32'd0);
    step();
    check("t3_delayed_flush", 32'(flush_valid), 32'd1);
    check("t3_flush_delayed", 32'(flush_delayed), 32'd1);
    step();

    // T4: compressed not-taken at 0x400: head 0x402 matches, head 0x404 flushes to 0x402
    do_fetch(2'b11, 2'b01, 32'h3FE, 32'h402);
    do_res(1'b0, 1'b0, 1'b1, 32'h400, 32'h0, 3'd2, 1'b1);
    check("t4_comp_match", 32'(flush_valid), 32'd0);
    check("t4_stat_branches", 32'(stat_branches), 32'd4);
    do_fetch(2'b11, 2'b01, 32'h3FE, 32'h404);
    exp_q.push_back({1'b0, 1'b1, 3'd6, 32'h402});
    do_res(1'b0, 1'b0, 1'b1, 32'h400, 32'h0, 3'd6, 1'b1);
    check("t4_comp_mismatch", 32'(flush_valid), 32'd1);
    check("t4_stat_mispredicts", 32'(stat_mispredicts), 32'd3);
    step();

    // T5: fill. The first group pushes 1 (must_capture=0), then 2+2+2 -> 7 entries.
    do_fetch(2'b11, 2'b11, 32'hA00, 32'hA04);
    model_q.push_back(32'hA04);
    for (int k = 1; k < 4; k++) begin
      do_fetch(2'b11, 2'b11, 32'hA00 + 32'(8*k), 32'hA04 + 32'(8*k));
      model_q.push_back(32'hA00 + 32'(8*k));
      model_q.push_back(32'hA04 + 32'(8*k));
    end
    check("t5_full_not_ready", 32'(fetch_ready), 32'd0);
    res_matching_head();
    check("t5_one_pop_ready", 32'(fetch_ready), 32'd1);
    while (model_q.size() > 0) res_matching_head();

    // preload to DEPTH-FETCH_W, then simultaneous push2/pop1 + a solo pop, 12 times (24 pushes)
    for (int k = 0; k < 3; k++) begin
      do_fetch(2'b11, 2'b11, 32'hB00 + 32'(8*k), 32'hB04 + 32'(8*k));
      model_q.push_back(32'hB00 + 32'(8*k));
      model_q.push_back(32'hB04 + 32'(8*k));
    end
    for (int j = 0; j < 12; j++) begin
      logic [31:0] t;
      model_q.push_back(32'hC00 + 32'(8*j));
      model_q.push_back(32'hC04 + 32'(8*j));
      t = model_q.pop_front();
      do_both(32'hC00 + 32'(8*j), 32'hC04 + 32'(8*j), t);
      res_matching_head();
    end
    while (model_q.size() > 0) res_matching_head();
    // 5 earlier + 7 fill + 30 wrap resolutions
    check("t5_stat_branches", 32'(stat_branches), 32'd42);
    check("t5_stat_mispredicts", 32'(stat_mispredicts), 32'd3);

    // T6: ext_flush coincident with a mismatching resolution
    do_fetch(2'b11, 2'b11, 32'h2000, 32'h2004);
    ext_flush = 1'b1;
    set_res(1'b1, 1'b0, 1'b0, 32'h2000, 32'hDEAD0, 3'd2, 1'b0);
    step();
    clear_inputs();
    check("t6_ext_no_flush", 32'(flush_valid), 32'd0);
    check("t6_ext_res_ready", 32'(res_ready), 32'd1);
    check("t6_ext_fetch_ready", 32'(fetch_ready), 32'd1);
    // With must_capture=0, a lone lane-0 fetch captures nothing,
    // so the next resolution finds an empty FIFO.
    do_fetch(2'b01, 2'b00, 32'h600, 32'h604);
    do_res(1'b0, 1'b0, 1'b0, 32'h5FC, 32'h0, 3'd1, 1'b0);
    check("t6_fifo_mc_cleared", 32'(res_ready), 32'd0);
    ext_flush = 1'b1;
    step();
    clear_inputs();
    check("t6_ext_clears_pending", 32'(res_ready), 32'd1);
    check("t6_stat_branches", 32'(stat_branches), 32'd42);

    // CSR redirect with an empty FIFO
    exp_q.push_back({1'b0, 1'b1, 3'd4, 32'h8000});
    do_res(1'b0, 1'b1, 1'b0, 32'h700, 32'h8000, 3'd4, 1'b1);
    check("t6_csr_flush", 32'(flush_valid), 32'd1);
    check("t6_csr_no_branch_count", 32'(stat_branches), 32'd42);
    check("t6_csr_mispredicts", 32'(stat_mispredicts), 32'd4);
    step();

    // asynchronous reset while a resolution is pending
    do_res(1'b0, 1'b0, 1'b0, 32'h900, 32'h0, 3'd7, 1'b0);
    check("t6_pending_before_rst", 32'(res_ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_res_ready", 32'(res_ready), 32'd1);
    check("rst_async_fetch_ready", 32'(fetch_ready), 32'd1);
    check("rst_async_stat_branches", 32'(stat_branches), 32'd0);
    check("rst_async_stat_mispredicts", 32'(stat_mispredicts), 32'd0);
    step();
    rst = 1'b0;
    repeat (3) step();

    check("flush_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
